// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the writeback end: widths, writeback select codes,
// holding-stage state encodings and the held-request payload.
package cpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NREG      = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wbSel_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        PEND  = 2'b01,
        FULL  = 2'b10
    } wbState_t;

    // Held request: destination, write enable and the already-selected writeback value.
    typedef struct packed {
        logic                 regWrite;
        logic [REG_IDX_W-1:0] writeReg;
        logic [XLEN-1:0]      value;
    } wbHold_t;

endpackage

// File: rtl/regfile_core.sv
// 32 x XLEN register array: async clear, one synchronous write port,
// two combinational read ports, register 0 hard-wired to zero.
module regfile_core
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 writeEn,
    input  logic [REG_IDX_W-1:0] writeAddr,
    input  logic [XLEN-1:0]      writeData,
    input  logic [REG_IDX_W-1:0] readAddr1,
    input  logic [REG_IDX_W-1:0] readAddr2,
    output logic [XLEN-1:0]      readData1,
    output logic [XLEN-1:0]      readData2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (writeEn && (writeAddr != '0)) begin
            regs[writeAddr] <= writeData;
        end
    end

    assign readData1 = (readAddr1 == '0) ? '0 : regs[readAddr1];
    assign readData2 = (readAddr2 == '0) ? '0 : regs[readAddr2];

endmodule

// File: rtl/regfile_wb.sv
// Writeback stage: one-entry holding FSM (EMPTY/PEND/FULL) that selects the writeback
// value, waits for load data, commits into the register file and bypasses pending writes.
module regfile_wb
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 WbValid,
    output logic                 WbReady,
    input  logic                 RegWrite,
    input  logic [1:0]           MemtoReg,
    input  logic [REG_IDX_W-1:0] WriteReg,
    input  logic [XLEN-1:0]      ALUResult,
    input  logic [XLEN-1:0]      PCPlus4,
    input  logic [XLEN-1:0]      Outimm,
    input  logic                 MemRvalid,
    input  logic [XLEN-1:0]      MemRdata,
    input  logic [REG_IDX_W-1:0] ReadReg1,
    input  logic [REG_IDX_W-1:0] ReadReg2,
    output logic [XLEN-1:0]      A,
    output logic [XLEN-1:0]      B,
    output logic                 Stall
);

    wbState_t        state;
    wbState_t        stateNext;
    wbHold_t         hold;
    wbHold_t         holdNext;
    wbSel_t          sel;
    logic            accept;
    logic            commit;
    logic [XLEN-1:0] arrayData1;
    logic [XLEN-1:0] arrayData2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            hold  <= '0;
        end else begin
            state <= stateNext;
            hold  <= holdNext;
        end
    end

    // FULL commits at the edge while a same-cycle accept refills the entry.
    always_comb begin
        stateNext = state;
        holdNext  = hold;
        commit    = 1'b0;
        sel       = wbSel_t'(MemtoReg);
        WbReady   = (state == EMPTY) || (state == FULL);
        accept    = WbValid && WbReady;

        case (state)
            EMPTY: ;
            PEND: begin
                if (MemRvalid) begin
                    holdNext.value = MemRdata;
                    stateNext      = FULL;
                end
            end
            FULL: begin
                commit    = hold.regWrite;
                stateNext = EMPTY;
            end
            default: stateNext = EMPTY;
        endcase

        if (accept) begin
            holdNext.regWrite = RegWrite;
            holdNext.writeReg = WriteReg;
            case (sel)
                WB_ALU:  holdNext.value = ALUResult;
                WB_MEM:  holdNext.value = '0;
                WB_PC4:  holdNext.value = PCPlus4;
                WB_IMM:  holdNext.value = Outimm;
                default: holdNext.value = '0;
            endcase
            stateNext = (sel == WB_MEM) ? PEND : FULL;
        end
    end

    regfile_core uCore (
        .clk       (clk),
        .rst       (rst),
        .writeEn   (commit),
        .writeAddr (hold.writeReg),
        .writeData (hold.value),
        .readAddr1 (ReadReg1),
        .readAddr2 (ReadReg2),
        .readData1 (arrayData1),
        .readData2 (arrayData2)
    );

    // Bypass the committing value so reads never see a stale array entry.
    always_comb begin
        A = arrayData1;
        B = arrayData2;
        if (ReadReg1 == '0) begin
            A = '0;
        end else if ((state == FULL) && hold.regWrite && (hold.writeReg == ReadReg1)) begin
            A = hold.value;
        end
        if (ReadReg2 == '0) begin
            B = '0;
        end else if ((state == FULL) && hold.regWrite && (hold.writeReg == ReadReg2)) begin
            B = hold.value;
        end
    end

    assign Stall = (state == PEND) && hold.regWrite && (hold.writeReg != '0) &&
                   ((hold.writeReg == ReadReg1) || (hold.writeReg == ReadReg2));

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: stimulus queues architectural events, a negedge
// monitor applies them to a plain register-array model and checks A/B/WbReady/Stall.
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic        WbValid;
    logic        WbReady;
    logic        RegWrite;
    logic [1:0]  MemtoReg;
    logic [4:0]  WriteReg;
    logic [31:0] ALUResult;
    logic [31:0] PCPlus4;
    logic [31:0] Outimm;
    logic        MemRvalid;
    logic [31:0] MemRdata;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] A;
    logic [31:0] B;
    logic        Stall;

    regfile_wb dut (
        .clk       (clk),
        .rst       (rst),
        .WbValid   (WbValid),
        .WbReady   (WbReady),
        .RegWrite  (RegWrite),
        .MemtoReg  (MemtoReg),
        .WriteReg  (WriteReg),
        .ALUResult (ALUResult),
        .PCPlus4   (PCPlus4),
        .Outimm    (Outimm),
        .MemRvalid (MemRvalid),
        .MemRdata  (MemRdata),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .A         (A),
        .B         (B),
        .Stall     (Stall)
    );

    localparam int K_WRITE   = 0;
    localparam int K_PEND    = 1;
    localparam int K_RESOLVE = 2;

    typedef struct {
        int          at;
        int          kind;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        rw;
    } ev_t;

    ev_t evQ[$];

    int vectors = 0;
    int miscompares = 0;
    int edgeCnt = 0;

    // Stimulus-side view: is a load outstanding (so the stage cannot accept)?
    logic       sPend = 1'b0;
    logic [4:0] sPendRd = '0;
    logic       sPendRw = 1'b0;

    // Monitor-side architectural model.
    logic [31:0] model [32];
    logic        mPend = 1'b0;
    logic [4:0]  mPendRd = '0;
    logic        mPendRw = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %h expected %h (rr1=%0d rr2=%0d)",
                     name, edgeCnt, act, exp, ReadReg1, ReadReg2);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
            mPend = 1'b0;
            chk("rst_A", A, 32'h0);
            chk("rst_B", B, 32'h0);
            chk("rst_WbReady", {31'h0, WbReady}, 32'h1);
            chk("rst_Stall", {31'h0, Stall}, 32'h0);
        end else begin
            while (evQ.size() > 0 && evQ[0].at <= edgeCnt) begin
                ev_t ev;
                ev = evQ.pop_front();
                if (ev.kind == K_PEND) begin
                    mPend   = 1'b1;
                    mPendRd = ev.rd;
                    mPendRw = ev.rw;
                end else begin
                    if (ev.kind == K_RESOLVE) mPend = 1'b0;
                    if (ev.rw && ev.rd != 5'd0) model[ev.rd] = ev.val;
                end
            end
            chk("A", A, (ReadReg1 == 5'd0) ? 32'h0 : model[ReadReg1]);
            chk("B", B, (ReadReg2 == 5'd0) ? 32'h0 : model[ReadReg2]);
            chk("WbReady", {31'h0, WbReady}, {31'h0, !mPend});
            chk("Stall", {31'h0, Stall},
                {31'h0, mPend && mPendRw && (mPendRd != 5'd0) &&
                        ((mPendRd == ReadReg1) || (mPendRd == ReadReg2))});
        end
    end

    // One cycle of stimulus; queues what becomes architecturally visible at the next edge.
    task automatic step(input logic v, input logic rw, input logic [1:0] sel,
                        input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [31:0] imm, input logic mv, input logic [31:0] md,
                        input logic [4:0] r1, input logic [4:0] r2, output logic acc);
        int e;
        logic [31:0] val;
        @(posedge clk);
        #1;
        WbValid = v; RegWrite = rw; MemtoReg = sel; WriteReg = wr;
        ALUResult = alu; PCPlus4 = pc4; Outimm = imm;
        MemRvalid = mv; MemRdata = md; ReadReg1 = r1; ReadReg2 = r2;
        e = edgeCnt + 1;
        acc = v && !sPend;
        if (sPend && mv) begin
            evQ.push_back('{at: e, kind: K_RESOLVE, rd: sPendRd, val: md, rw: sPendRw});
            sPend = 1'b0;
        end
        if (acc) begin
            if (sel == 2'b01) begin
                evQ.push_back('{at: e, kind: K_PEND, rd: wr, val: 32'h0, rw: rw});
                sPend = 1'b1; sPendRd = wr; sPendRw = rw;
            end else begin
                val = (sel == 2'b00) ? alu : (sel == 2'b10) ? pc4 : imm;
                evQ.push_back('{at: e, kind: K_WRITE, rd: wr, val: val, rw: rw});
            end
        end
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2,
                        input logic mv = 1'b0, input logic [31:0] md = 32'h0);
        logic dummy;
        step(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, mv, md, r1, r2, dummy);
    endtask

    task automatic req(input logic rw, input logic [1:0] sel, input logic [4:0] wr,
                       input logic [31:0] data, input logic [4:0] r1, input logic [4:0] r2);
        logic dummy;
        step(1'b1, rw, sel, wr, data, data, data, 1'b0, 32'h0, r1, r2, dummy);
    endtask

    initial begin
        logic        hv, hrw, acc, mv;
        logic [1:0]  hsel;
        logic [4:0]  hwr, r1, r2;
        logic [31:0] halu, hpc, himm, md;

        rst = 1'b1; WbValid = 0; RegWrite = 0; MemtoReg = 0; WriteReg = 0;
        ALUResult = 0; PCPlus4 = 0; Outimm = 0; MemRvalid = 0; MemRdata = 0;
        ReadReg1 = 5'd5; ReadReg2 = 5'd7;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset while a load to x5 is pending
        req(1'b1, 2'b00, 5'd5, 32'h1234, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        req(1'b1, 2'b01, 5'd5, 32'h0, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        idle(5'd0, 5'd5);
        @(posedge clk);
        #1;
        rst = 1'b1; WbValid = 1'b0; MemRvalid = 1'b0;
        evQ.delete(); sPend = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
        repeat (3) idle(5'd5, 5'd5, 1'b1, 32'hCAFE_F00D);

        // ALU write with bypass then array read
        req(1'b1, 2'b00, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0);
        repeat (2) idle(5'd3, 5'd0);

        // Load with three-cycle data latency
        req(1'b1, 2'b01, 5'd7, 32'h0, 5'd0, 5'd7);
        repeat (2) idle(5'd0, 5'd7);
        idle(5'd0, 5'd7, 1'b1, 32'h0000_00FF);
        repeat (2) idle(5'd0, 5'd7);

        // Register 0 via immediate path
        req(1'b1, 2'b11, 5'd0, 32'hFFFF0000, 5'd0, 5'd0);
        repeat (2) idle(5'd0, 5'd0);

        // Back-to-back ALU writes
        for (int i = 1; i <= 4; i++) req(1'b1, 2'b00, 5'(i), 32'(i), 5'(i), 5'(i - 1));
        idle(5'd1, 5'd2);
        idle(5'd3, 5'd4);

        // PCPlus4 select, then RegWrite=0 leaves x31 alone
        req(1'b1, 2'b10, 5'd31, 32'h0040_0008, 5'd31, 5'd0);
        repeat (2) idle(5'd31, 5'd0);
        req(1'b0, 2'b11, 5'd31, 32'h1234_5678, 5'd31, 5'd0);
        repeat (2) idle(5'd31, 5'd31);

        // Randomized traffic; an unaccepted request is held stable
        hv = 0; hrw = 0; hsel = 0; hwr = 0; halu = 0; hpc = 0; himm = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!hv && ($urandom_range(0, 9) < 6)) begin
                hv   = 1'b1;
                hrw  = ($urandom_range(0, 7) != 0);
                hsel = 2'($urandom_range(0, 3));
                hwr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(0, 7));
                halu = $urandom; hpc = $urandom; himm = $urandom;
            end
            mv = sPend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            md = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            step(hv, hrw, hsel, hwr, halu, hpc, himm, mv, md, r1, r2, acc);
            if (acc) hv = 1'b0;
        end

        // Drain any outstanding load and sweep the final register contents
        for (int n = 0; n < 8 && sPend; n++) idle(5'd1, 5'd2, 1'b1, $urandom);
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
        if (sPend) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: load still pending got 1 expected 0");
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
